// File: rtl/punc_debug_pkg.sv
// Shared definitions for the PUnC debug scanner: record kinds, FSM states
// and default sizing for the debug read interface.
package punc_debug_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RF_REGS = 8;

  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_RF  = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_RF,
    ST_MEM,
    ST_FLUSH
  } scan_state_t;

endpackage

// File: rtl/punc_debug_outreg.sv
// Single-entry valid/ready output register. A load overwrites the entry
// (only requested when the entry is empty or being accepted); otherwise an
// accept empties it. While stalled the entry holds every field.
module punc_debug_outreg
  import punc_debug_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [1:0]        ld_kind,
  input  logic [DATA_W-1:0] ld_index,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_reg;
  logic [1:0]        kind_reg;
  logic [DATA_W-1:0] index_reg;
  logic [DATA_W-1:0] data_reg;

  // A new record may enter when the slot is empty or drains this cycle.
  assign can_load = !valid_reg || out_ready;

  // Capture on load, clear valid on accept without a replacing load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      kind_reg  <= '0;
      index_reg <= '0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      kind_reg  <= ld_kind;
      index_reg <= ld_index;
      data_reg  <= ld_data;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_kind  = kind_reg;
  assign out_index = index_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/punc_debug_scanner.sv
// Host-side PUnC debug scanner: sweeps PC, R0..R(RF_REGS-1) and a memory
// window through the processor debug ports and emits one record per load
// on a valid/ready stream. Debug addresses come straight from the index
// registers so the combinational debug data is settled for the load cycle.
module punc_debug_scanner
  import punc_debug_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RF_REGS = DEF_RF_REGS,
  localparam int RF_AW  = $clog2(RF_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [DATA_W-1:0] word_count,
  output logic [DATA_W-1:0] mem_debug_addr,
  output logic [RF_AW-1:0]  rf_debug_addr,
  input  logic [DATA_W-1:0] mem_debug_data,
  input  logic [DATA_W-1:0] rf_debug_data,
  input  logic [DATA_W-1:0] pc_debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  scan_state_t       state_reg, state_next;
  logic [DATA_W-1:0] count_reg, count_next;
  logic [DATA_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] off_reg, off_next;
  logic [RF_AW-1:0]  rf_idx_reg, rf_idx_next;
  logic              done_reg, done_next;

  logic              can_load;
  logic              load;
  logic [1:0]        ld_kind;
  logic [DATA_W-1:0] ld_index;
  logic [DATA_W-1:0] ld_data;

  // State, latched window and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      mem_addr_reg <= '0;
      off_reg      <= '0;
      rf_idx_reg   <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      mem_addr_reg <= mem_addr_next;
      off_reg      <= off_next;
      rf_idx_reg   <= rf_idx_next;
      done_reg     <= done_next;
    end
  end

  // Sequencer: pick the record source, decide loads and advance indices.
  // The MEM exit compares the offset against count-1 so a full 0xFFFF
  // window terminates without relying on counter wrap.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    mem_addr_next = mem_addr_reg;
    off_next      = off_reg;
    rf_idx_next   = rf_idx_reg;
    done_next     = 1'b0;
    load          = 1'b0;
    ld_kind       = KIND_PC;
    ld_index      = '0;
    ld_data       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !done_reg) begin
          state_next    = ST_PC;
          count_next    = word_count;
          mem_addr_next = base_addr;
          off_next      = '0;
          rf_idx_next   = '0;
        end
      end
      ST_PC: begin
        ld_kind = KIND_PC;
        ld_data = pc_debug_data;
        if (can_load) begin
          load        = 1'b1;
          rf_idx_next = '0;
          state_next  = ST_RF;
        end
      end
      ST_RF: begin
        ld_kind  = KIND_RF;
        ld_index = DATA_W'(rf_idx_reg);
        ld_data  = rf_debug_data;
        if (can_load) begin
          load        = 1'b1;
          rf_idx_next = rf_idx_reg + 1'b1;
          if (rf_idx_reg == RF_AW'(RF_REGS - 1)) begin
            state_next = (count_reg != '0) ? ST_MEM : ST_FLUSH;
          end
        end
      end
      ST_MEM: begin
        ld_kind  = KIND_MEM;
        ld_index = mem_addr_reg;
        ld_data  = mem_debug_data;
        if (can_load) begin
          load          = 1'b1;
          mem_addr_next = mem_addr_reg + 1'b1;
          off_next      = off_reg + 1'b1;
          if (off_reg == count_reg - 1'b1) begin
            state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (can_load) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  punc_debug_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .ld_kind   (ld_kind),
    .ld_index  (ld_index),
    .ld_data   (ld_data),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_kind  (out_kind),
    .out_index (out_index),
    .out_data  (out_data)
  );

  assign mem_debug_addr = mem_addr_reg;
  assign rf_debug_addr  = rf_idx_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign done           = done_reg;

endmodule

// File: tb/tb_punc_debug_scanner.sv
// Self-checking bench for punc_debug_scanner: builds the expected record
// list for each snapshot from the processor model and compares every
// accepted record, stall stability and done timing on each cycle.
module tb_punc_debug_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic [15:0] mem_debug_addr;
  logic [2:0]  rf_debug_addr;
  logic [15:0] mem_debug_data;
  logic [15:0] rf_debug_data;
  logic [15:0] pc_debug_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [15:0] out_index;
  logic [15:0] out_data;
  logic        busy;
  logic        done;

  // processor model
  logic [15:0] pc_val;
  logic [15:0] rf_vals [0:7];

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  assign mem_debug_data = memfn(mem_debug_addr);
  assign rf_debug_data  = rf_vals[rf_debug_addr];
  assign pc_debug_data  = pc_val;

  always #5 clk = ~clk;

  punc_debug_scanner dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .mem_debug_addr (mem_debug_addr),
    .rf_debug_addr  (rf_debug_addr),
    .mem_debug_data (mem_debug_data),
    .rf_debug_data  (rf_debug_data),
    .pc_debug_data  (pc_debug_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_kind       (out_kind),
    .out_index      (out_index),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard state
  logic [33:0] exp_q [$];
  logic [33:0] log_rec [0:63];
  int          rec_count;
  int          done_seen;
  int          cyc = 0;
  int          start_cyc;
  int          first_valid_cyc;
  int          last_acc_cyc;
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [33:0] hold_rec;
  bit          mem_const_en = 1'b0;
  logic [15:0] mem_const_val;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: inputs change just after posedge, so at negedge both
  // the handshake inputs and DUT outputs for the coming edge are settled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev)
        chk("stall_hold", {out_valid, out_kind, out_index, out_data}, {1'b1, hold_rec});
      if (out_valid)
        chk("busy_while_valid", busy, 1);
      if (out_valid && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_record", {out_kind, out_index, out_data}, 34'h3_FFFF_FFFF);
        end else begin
          chk("record", {out_kind, out_index, out_data}, exp_q.pop_front());
        end
        $display("REC %0d kind=%0d index=%h data=%h", rec_count, out_kind, out_index, out_data);
        if (rec_count < 64) log_rec[rec_count] = {out_kind, out_index, out_data};
        rec_count++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_seen++;
        chk("done_timing", cyc, last_acc_cyc + 1);
        chk("busy_at_done", busy, 0);
        chk("queue_empty_at_done", exp_q.size(), 0);
      end
      if (mem_const_en && busy)
        chk("mem_addr_const", mem_debug_addr, mem_const_val);
      stall_prev = out_valid && !out_ready;
      hold_rec   = {out_kind, out_index, out_data};
    end
  end

  // One complete snapshot: mode 0 ready high, 1 pattern 1,0,0,1, 2 random.
  task automatic run_scan(input logic [15:0] pc, input logic [15:0] base,
                          input logic [15:0] cnt, input int mode,
                          input int restart_at, input bit const_chk);
    int  phase;
    bit  restarted;
    pc_val = pc;
    for (int i = 0; i < 8; i++) rf_vals[i] = 16'($urandom);
    exp_q.delete();
    exp_q.push_back({2'd0, 16'h0000, pc});
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd1, 16'(i), rf_vals[i]});
    for (int k = 0; k < int'(cnt); k++) exp_q.push_back({2'd2, 16'(base + 16'(k)), memfn(16'(base + 16'(k)))});
    rec_count = 0; done_seen = 0; first_valid_cyc = -1; last_acc_cyc = -100;
    phase = 0; restarted = 1'b0;
    mem_const_val = base; mem_const_en = const_chk;
    stall_prev = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;
    base_addr = base; word_count = cnt; start = 1'b1; start_cyc = cyc;
    out_ready = 1'b1;
    for (int c = 0; c < 3000 && done_seen == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart_at >= 0 && !restarted && rec_count == restart_at) begin
        start = 1'b1; base_addr = 16'($urandom); word_count = 16'($urandom_range(1, 9));
        restarted = 1'b1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (phase % 4 == 0) || (phase % 4 == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      phase++;
    end
    if (done_seen == 0) chk("done_timeout", 0, 1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_seen, 1);
    chk("record_count", rec_count, 9 + int'(cnt));
    chk("queue_drained", exp_q.size(), 0);
    chk("first_latency", first_valid_cyc, start_cyc + 2);
    mem_const_en = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
    pc_val = '0;
    for (int i = 0; i < 8; i++) rf_vals[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {out_valid, busy, done, out_kind, out_index, out_data}, '0);
    chk("reset_addrs", {mem_debug_addr, rf_debug_addr}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {out_valid, busy, done}, 0);

    // basic window, ready always high
    run_scan(16'h3005, 16'h3000, 16'd2, 0, -1, 1'b0);
    chk("lit_pc", log_rec[0], {2'd0, 16'h0000, 16'h3005});
    chk("lit_r0_kind_idx", log_rec[1][33:16], {2'd1, 16'h0000});
    chk("lit_r7_kind_idx", log_rec[8][33:16], {2'd1, 16'h0007});
    chk("lit_mem0", log_rec[9], {2'd2, 16'h3000, 16'h5A6A});
    chk("lit_mem1", log_rec[10], {2'd2, 16'h3001, 16'h5B6A});

    // same window with back-pressure 1,0,0,1
    run_scan(16'h3005, 16'h3000, 16'd2, 1, -1, 1'b0);
    chk("lit_bp_mem1", log_rec[10], {2'd2, 16'h3001, 16'h5B6A});

    // address wrap
    run_scan(16'($urandom), 16'hFFFE, 16'd3, 1, -1, 1'b0);
    chk("lit_wrap0", log_rec[9][31:16], 16'hFFFE);
    chk("lit_wrap1", log_rec[10][31:16], 16'hFFFF);
    chk("lit_wrap2", log_rec[11][31:16], 16'h0000);

    // empty window: no memory records, address stays at base
    run_scan(16'($urandom), 16'h1234, 16'd0, 2, -1, 1'b1);

    // start pulsed while the 4th record is in flight
    run_scan(16'($urandom), 16'h4000, 16'd5, 0, 3, 1'b0);

    // reset in the middle of the RF phase with a record pending
    mon_en = 1'b0;
    @(posedge clk); #1;
    base_addr = 16'h1000; word_count = 16'd4; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_kind == 2'd1 && out_index == 16'd3) found = 1'b1;
    end
    chk("rst_reach_rf", found, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_clears", {out_valid, busy, done}, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid_no_done", {done, busy, out_valid}, 0);
    end
    run_scan(16'hBEEF, 16'h0200, 16'd1, 0, -1, 1'b0);
    chk("lit_fresh_pc", log_rec[0], {2'd0, 16'h0000, 16'hBEEF});

    // randomized windows and back-pressure
    for (int t = 0; t < 6; t++)
      run_scan(16'($urandom), 16'($urandom), 16'($urandom_range(0, 24)), 2, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/punc_debug_scanner.md
Name: punc_debug_scanner

Overview:
- Host-side counterpart of the PUnC processor's debug read interface.
- Drives mem_debug_addr and rf_debug_addr, samples mem_debug_data, rf_debug_data and pc_debug_data, and serialises a snapshot as a valid/ready record stream. Order: PC, then R0..R7, then a memory window.
- Sits beside the PUnC top in the testbench/FPGA harness so processor state can be dumped without touching processor control.

Parameters:
- DATA_W, 16, width of debug data words and memory addresses (LC3 word).
- RF_REGS, 8, number of register-file entries swept (rf_debug_addr width = 3).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a snapshot; ignored while busy
- base_addr  input  16  first memory address of the window; sampled on accepted start
- word_count  input  16  number of memory words to dump; sampled on accepted start; 0 = no memory records
- mem_debug_addr  output  16  to processor debug memory address
- rf_debug_addr  output  3  to processor debug RF address
- mem_debug_data  input  16  from processor; combinational function of mem_debug_addr
- rf_debug_data  input  16  from processor; combinational function of rf_debug_addr
- pc_debug_data  input  16  from processor; current PC
- out_valid  output  1  record available
- out_ready  input  1  consumer accepts record
- out_kind  output  2  record type: 0 = PC, 1 = RF, 2 = MEM
- out_index  output  16  PC: 0; RF: register number; MEM: memory address
- out_data  output  16  sampled value
- busy  output  1  high from accepted start until the cycle done pulses
- done  output  1  one-cycle pulse after the final record is accepted

Behaviour:
- Reset: state IDLE; out_valid, busy, done = 0; out_kind, out_index, out_data = 0; mem_debug_addr = 0; rf_debug_addr = 0; internal counters = 0.
- FSM states: IDLE, PC, RF, MEM, FLUSH.
  - IDLE: when start = 1, latch base_addr and word_count, set busy, go to PC.
  - PC: on load, go to RF with rf index 0.
  - RF: loads R0..R7 in order. After the R7 load, go to MEM if the latched count is nonzero, else FLUSH.
  - MEM: loads addresses base, base+1, ..., base+count-1. After the last load, go to FLUSH.
  - FLUSH: waits until the output register is empty or is being accepted. Then done = 1 for one cycle, busy = 0, go to IDLE.
- Load condition: a scanning state is active and (out_valid = 0 or out_ready = 1). On a load:
  - The output register captures kind, index and the combinational debug data for the address currently driven.
  - out_valid is set.
  - The index register advances.
- mem_debug_addr and rf_debug_addr are driven directly from the index registers (registered outputs). Data is therefore stable for the entire load cycle.
- Throughput: one record per cycle while out_ready stays high.
- Latency: first record (PC) is valid 2 cycles after the start cycle.
- Total records = 1 + RF_REGS + word_count.
- Acceptance: out_valid clears when out_ready = 1 and no new load occurs in the same cycle.
- Stall: while out_valid = 1 and out_ready = 0, all out_* hold stable and the index registers do not advance.
- Address arithmetic: mem address = base + offset, mod 2^16. Example: base 0xFFFE, count 4 dumps 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Offset counter is 16 bits. count = 0xFFFF is legal. The MEM exit test is offset == count-1, not a wrap compare.
- start while busy: ignored; latched base and count are unchanged.
- start in the same cycle as done: ignored. A new snapshot needs start in a cycle where busy = 0 and done = 0.
- rst mid-scan: immediate return to IDLE with all reset values. A pending record is dropped and no done pulse is produced.
- PC is sampled once, at its load. The processor keeps running, so RF and MEM records reflect later cycles. Coherent snapshots require the harness to hold the processor in reset or a halt state.

Decomposition:
- Shared package punc_debug_pkg:
  - record kind constants KIND_PC = 2'd0, KIND_RF = 2'd1, KIND_MEM = 2'd2
  - FSM state encoding
  - RF_REGS and DATA_W defaults
- One natural sub-module: punc_debug_outreg, the single-entry valid/ready output register with load/accept logic. The sequencer FSM and counters stay in the top.

Test Plan:
- Reset, then start with base 0x3000, count 2, out_ready = 1, PC = 0x3005 → 11 consecutive records:
  - (0, 0, 0x3005)
  - (1, 0..7, R0..R7)
  - (2, 0x3000, M[0x3000]) and (2, 0x3001, M[0x3001])
  - done pulses the cycle after the last accept; busy falls with it.
- Same run with out_ready toggled 1,0,0,1 repeating → identical record sequence. out_* stay stable during every stall; no record is duplicated or skipped.
- base 0xFFFE, count 3 → MEM indices 0xFFFE, 0xFFFF, 0x0000.
- count 0 → exactly 9 records (PC + 8 RF); mem_debug_addr is never changed from the latched base.
- start pulsed again at the 4th record → ignored; sequence and record count unchanged.
- rst asserted while out_valid = 1 in the RF phase → next cycle out_valid = 0, busy = 0, no done. A fresh start restarts from the PC record.
